// File: rtl/lsu_bus_if.sv
// Load/store unit front end: turns one decoded memory access into a single
// req/ack bus transfer, aligning store lanes and extending load results.
module lsu_bus_if #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_valid,
  input  logic              acc_load,
  input  logic [3:0]        mem_rw,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [1:0]        dbg_state
);

  // Bus handshake: bus_req stays high with address/data/enables stable until
  // the cycle bus_ack is sampled high; only one transfer is ever outstanding.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             to_err;
  logic             ld_active;
  logic             ld_signed;
  logic [1:0]       ld_size;
  logic [1:0]       ld_off;

  logic [1:0]  off;
  logic        is_store, is_load, is_acc;
  logic [1:0]  size;
  logic        size_ok, aligned, legal;
  logic [3:0]  size_mask;
  logic [31:0] shifted, ext;

  // Size code: 0 byte, 1 half, 2 word.
  always_comb begin
    off       = addr[1:0];
    is_store  = (mem_rw != 4'b0000);
    is_load   = (mem_rw == 4'b0000) && acc_load;
    is_acc    = acc_valid && (is_store || is_load);
    size      = 2'd0;
    size_ok   = 1'b0;
    aligned   = 1'b1;
    size_mask = 4'b0001;
    if (is_store) begin
      case (mem_rw)
        4'b0001: begin size = 2'd0; size_ok = 1'b1; end
        4'b0011: begin size = 2'd1; size_ok = 1'b1; end
        4'b1111: begin size = 2'd2; size_ok = 1'b1; end
        default: ;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: begin size = 2'd0; size_ok = 1'b1; end
        3'b001, 3'b101: begin size = 2'd1; size_ok = 1'b1; end
        3'b010:         begin size = 2'd2; size_ok = 1'b1; end
        default: ;
      endcase
    end
    case (size)
      2'd1:    begin aligned = ~off[0];         size_mask = 4'b0011; end
      2'd2:    begin aligned = (off == 2'b00); size_mask = 4'b1111; end
      default: begin aligned = 1'b1;           size_mask = 4'b0001; end
    endcase
    legal = size_ok && aligned;
  end

  always_comb begin
    shifted = bus_rdata >> {ld_off, 3'b000};
    case (ld_size)
      2'd0:    ext = ld_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'd1:    ext = ld_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (is_acc) state_n = legal ? BUS : ERR;
      BUS:  if (bus_ack || (cnt == CNT_LAST)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      to_err    <= 1'b0;
      ld_active <= 1'b0;
      ld_signed <= 1'b0;
      ld_size   <= 2'd0;
      ld_off    <= 2'd0;
      rdata     <= 32'h0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'h0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          cnt    <= '0;
          to_err <= 1'b0;
          if (is_acc && legal) begin
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_we    <= is_store;
            bus_be    <= size_mask << off;
            bus_wdata <= wdata << {off, 3'b000};
            ld_active <= is_load;
            ld_signed <= ~funct3[2];
            ld_size   <= size;
            ld_off    <= off;
          end
          if (is_acc && !legal) rdata <= 32'h0;
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // An ack on the final counted cycle still completes cleanly.
          if (bus_ack) begin
            rdata <= ld_active ? ext : 32'h0;
          end else if (cnt == CNT_LAST) begin
            to_err <= 1'b1;
            rdata  <= 32'h0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus_req   = (state == BUS);
    done      = (state == DONE) || (state == ERR);
    err       = (state == ERR) || ((state == DONE) && to_err);
    stall     = rst_n && ((state == BUS) || ((state == IDLE) && is_acc));
    dbg_state = state;
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: a spec-level access model feeds an expected
// completion queue, and a negedge compare process checks the bus and results.
module tb_lsu_bus_if;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid = 1'b0;
  logic        acc_load = 1'b0;
  logic [3:0]  mem_rw = 4'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_wdata, bus_addr;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected completion: {check_rdata, err, rdata}
  logic [33:0] exp_q[$];
  bit          bus_expected = 1'b0;
  logic [31:0] exp_addr  = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic [3:0]  exp_be    = 4'b0;
  logic        exp_we    = 1'b0;

  lsu_bus_if #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_load(acc_load),
    .mem_rw(mem_rw), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Access rules in plain arithmetic: size in bytes, alignment by modulo,
  // load value by shifting, truncating and re-biasing signed values.
  function automatic void model(input logic [3:0] rw, input logic ld, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                                output bit is_acc, output bit legal, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] ld_val);
    int bytes; bit sgn; int off; longint span; longint v;
    off = int'(a[1:0]);
    bytes = 0; sgn = 1'b0;
    is_acc = (rw != 4'b0000) || ld;
    if (rw != 4'b0000) begin
      case (rw)
        4'b0001: bytes = 1;
        4'b0011: bytes = 2;
        4'b1111: bytes = 4;
        default: bytes = 0;
      endcase
    end else begin
      case (f3)
        3'b000: begin bytes = 1; sgn = 1'b1; end
        3'b001: begin bytes = 2; sgn = 1'b1; end
        3'b010: bytes = 4;
        3'b100: bytes = 1;
        3'b101: bytes = 2;
        default: bytes = 0;
      endcase
    end
    legal  = (bytes != 0) && ((off % bytes) == 0);
    be     = legal ? 4'(((1 << bytes) - 1) << off) : 4'b0;
    bwd    = wd << (8 * off);
    ld_val = 32'h0;
    if (legal) begin
      span = longint'(1) << (8 * bytes);
      v = (longint'(brd) >> (8 * off)) % span;
      if (sgn && (v >= span / 2)) v = v - span;
      ld_val = v[31:0];
    end
  endfunction

  always @(negedge clk) begin : cmp
    logic [33:0] e;
    if (rst_n) begin
      if (bus_req) begin
        if (!bus_expected) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bus_req: got 1 expected 0");
        end else begin
          check("bus_addr", bus_addr, exp_addr);
          check("bus_we", 32'(bus_we), 32'(exp_we));
          check("bus_be", 32'(bus_be), 32'(exp_be));
          check("bus_wdata", bus_wdata, exp_wdata);
          check("stall_in_bus", 32'(stall), 32'd1);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_done: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          check("done_err", 32'(err), 32'(e[32]));
          if (e[33]) check("done_rdata", rdata, e[31:0]);
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  // ack_at = which bus_req cycle gets bus_ack (0 = never ack).
  task automatic run_access(input logic [3:0] rw, input logic ld, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] brd, input int ack_at);
    bit is_acc, legal; logic [3:0] be; logic [31:0] bwd, ldv;
    int req_cycles, done_cyc, cyc, exp_req;
    model(rw, ld, f3, a, wd, brd, is_acc, legal, be, bwd, ldv);
    @(posedge clk); #1;
    acc_valid = 1'b1; acc_load = ld; mem_rw = rw; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = brd; bus_ack = 1'b0;
    exp_addr = {a[31:2], 2'b00}; exp_we = (rw != 4'b0000); exp_be = be; exp_wdata = bwd;
    bus_expected = is_acc && legal;
    if (is_acc)
      exp_q.push_back({(!legal || (ack_at != 0 && rw == 4'b0000)),
                       (!legal || ack_at == 0), (legal ? ldv : 32'h0)});
    @(negedge clk);
    check("stall_at_accept", 32'(stall), 32'(is_acc));
    if (!is_acc) begin
      repeat (3) begin
        @(negedge clk);
        check("stall_ignored", 32'(stall), 32'd0);
      end
      acc_valid = 1'b0;
      return;
    end
    req_cycles = 0; done_cyc = 0; cyc = 0;
    while (done_cyc == 0 && cyc < TIMEOUT + 8) begin
      @(posedge clk); #1;
      cyc++;
      bus_ack = 1'b0;
      if (bus_req) begin
        req_cycles++;
        if (req_cycles == ack_at) bus_ack = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        check("stall_at_done", 32'(stall), 32'd0);
      end
    end
    exp_req = !legal ? 0 : (ack_at == 0 ? TIMEOUT : ack_at);
    check("req_cycles", 32'(req_cycles), 32'(exp_req));
    check("done_latency", 32'(done_cyc), 32'(exp_req + 1));
    // acc_valid stays high through the done cycle; it must not be re-accepted there.
    @(posedge clk); #1;
    acc_valid = 1'b0; bus_ack = 1'b0; bus_expected = 1'b0;
  endtask

  task automatic reset_mid_transfer();
    bit is_acc, legal; logic [3:0] be; logic [31:0] bwd, ldv;
    model(4'b1111, 1'b0, 3'b000, 32'h400, 32'h11223344, 32'h0, is_acc, legal, be, bwd, ldv);
    @(posedge clk); #1;
    acc_valid = 1'b1; acc_load = 1'b0; mem_rw = 4'b1111; funct3 = 3'b000;
    addr = 32'h400; wdata = 32'h11223344; bus_ack = 1'b0;
    exp_addr = 32'h400; exp_we = 1'b1; exp_be = be; exp_wdata = bwd; bus_expected = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("req_before_reset", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    acc_valid = 1'b0; bus_expected = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    bit ia, lg; logic [3:0] be; logic [31:0] bwd, ldv;
    model(4'b0000, 1'b1, 3'b000, 32'h201, 32'h0, 32'h0000F300, ia, lg, be, bwd, ldv);
    check("model_lb", ldv, 32'hFFFFFFF3);
    model(4'b0000, 1'b1, 3'b100, 32'h201, 32'h0, 32'h0000F300, ia, lg, be, bwd, ldv);
    check("model_lbu", ldv, 32'h000000F3);
    model(4'b0000, 1'b1, 3'b001, 32'h202, 32'h0, 32'h80010000, ia, lg, be, bwd, ldv);
    check("model_lh", ldv, 32'hFFFF8001);
    model(4'b0001, 1'b0, 3'b000, 32'h103, 32'hA5, 32'h0, ia, lg, be, bwd, ldv);
    check("model_sb_be", 32'(be), 32'h8);
    check("model_sb_wdata", bwd, 32'hA5000000);
    model(4'b0011, 1'b0, 3'b000, 32'h102, 32'h1234, 32'h0, ia, lg, be, bwd, ldv);
    check("model_sh_be", 32'(be), 32'hC);
    check("model_sh_wdata", bwd, 32'h12340000);
    model(4'b0000, 1'b1, 3'b010, 32'h302, 32'h0, 32'h0, ia, lg, be, bwd, ldv);
    check("model_lw_misaligned", 32'(lg), 32'd0);
    model(4'b0101, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, ia, lg, be, bwd, ldv);
    check("model_bad_code", 32'(lg), 32'd0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_bus_we", 32'(bus_we), 32'd0);
    check("reset_bus_be", 32'(bus_be), 32'd0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_bus_wdata", bus_wdata, 32'h0);
    check("reset_rdata", rdata, 32'h0);

    run_access(4'b1111, 1'b0, 3'b000, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    run_access(4'b0001, 1'b0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
    run_access(4'b0011, 1'b0, 3'b000, 32'h102, 32'h00001234, 32'h0, 2);
    run_access(4'b0000, 1'b1, 3'b000, 32'h201, 32'h0, 32'h0000F300, 1);
    check("rdata_hold_lb", rdata, 32'hFFFFFFF3);
    run_access(4'b0000, 1'b1, 3'b100, 32'h201, 32'h0, 32'h0000F300, 2);
    check("rdata_hold_lbu", rdata, 32'h000000F3);
    run_access(4'b0000, 1'b1, 3'b001, 32'h202, 32'h0, 32'h80010000, 1);
    check("rdata_hold_lh", rdata, 32'hFFFF8001);
    run_access(4'b0000, 1'b1, 3'b101, 32'h202, 32'h0, 32'h80010000, 4);
    run_access(4'b0000, 1'b1, 3'b010, 32'h300, 32'h0, 32'h12345678, 1);
    run_access(4'b0000, 1'b1, 3'b010, 32'h302, 32'h0, 32'h0, 1);
    check("rdata_after_err", rdata, 32'h0);
    run_access(4'b0101, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 1);
    run_access(4'b0000, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1);
    run_access(4'b0011, 1'b0, 3'b000, 32'h101, 32'hBEEF, 32'h0, 1);
    run_access(4'b0000, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 1);
    run_access(4'b0000, 1'b1, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0);
    reset_mid_transfer();
    run_access(4'b1111, 1'b0, 3'b000, 32'h500, 32'h55AA55AA, 32'h0, 2);
    run_access(4'b0000, 1'b1, 3'b000, 32'h503, 32'h0, 32'h7F000000, 1);
    check("rdata_hold_after_reset", rdata, 32'h0000007F);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
